// File: rtl/term_pkg.sv
// Shared definitions for the terminal command sender.
//   - Command bytes sent to the terminal buffer.
//   - Screen geometry used by the optional cursor tracker.
//   - FSM state and request-code encodings.
package term_pkg;

    localparam logic [7:0] CMD_UP      = 8'h6B;  // "k"
    localparam logic [7:0] CMD_DOWN    = 8'h6A;  // "j"
    localparam logic [7:0] CMD_LEFT    = 8'h68;  // "h"
    localparam logic [7:0] CMD_RIGHT   = 8'h6C;  // "l"
    localparam logic [7:0] CMD_REFRESH = 8'h20;  // " "

    localparam int TERM_COLS  = 40;
    localparam int TERM_CELLS = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        REQ_UP      = 3'd0,
        REQ_DOWN    = 3'd1,
        REQ_LEFT    = 3'd2,
        REQ_RIGHT   = 3'd3,
        REQ_REFRESH = 3'd4
    } req_t;

    function automatic logic [7:0] req_to_cmd(input req_t r);
        case (r)
            REQ_UP:    return CMD_UP;
            REQ_DOWN:  return CMD_DOWN;
            REQ_LEFT:  return CMD_LEFT;
            REQ_RIGHT: return CMD_RIGHT;
            default:   return CMD_REFRESH;
        endcase
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO holding pending request codes.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   push       write wr_data (ignored when full unless popping the same cycle)
//   pop        consume the head entry (ignored when empty)
//   wr_data    request code to enqueue
//   rd_data    head entry, valid whenever empty is low
//   full       DEPTH entries held
//   empty      no entries held
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/term_cmd_sender.sv
// Initiator for the terminal byte protocol. Single-cycle navigation/refresh
// requests are prioritised, queued, and issued one at a time as command bytes;
// response bytes are forwarded with their index, with a per-byte idle timeout.
// Optional build macro: TERM_CURSOR_TRACK_EN adds o_cursor_pos tracking.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   i_up/i_down/i_left/i_right/i_refresh   1-cycle request pulses
//   o_cmd, o_cmd_v                  command byte, valid held CMD_HOLD cycles
//   i_rsp, i_rsp_v                  response byte and strobe
//   o_char, o_char_v, o_char_idx    forwarded response byte, strobe, index
//   o_busy                          FSM active or requests pending
//   o_drop                          pulse: a request was lost
//   o_timeout                       pulse: response aborted by timeout
//   o_cursor_pos                    (TERM_CURSOR_TRACK_EN) cursor cell 0..1023
//
// state | meaning
// IDLE  | waiting for a queued request; pops and launches a command
// SEND  | o_cmd_v held high for CMD_HOLD cycles
// WAIT  | collecting response bytes until count reached or timeout
module term_cmd_sender
    import term_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int CMD_HOLD    = 2,
    parameter int REFRESH_LEN = 1024,
    parameter int TIMEOUT     = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_refresh,
    output logic [7:0] o_cmd,
    output logic       o_cmd_v,
    input  logic [7:0] i_rsp,
    input  logic       i_rsp_v,
    output logic [7:0] o_char,
    output logic       o_char_v,
    output logic [9:0] o_char_idx,
    output logic       o_busy,
    output logic       o_drop,
`ifdef TERM_CURSOR_TRACK_EN
    output logic [9:0] o_cursor_pos,
`endif
    output logic       o_timeout
);

    localparam int HW = (CMD_HOLD > 1) ? $clog2(CMD_HOLD) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic [10:0]   rcv, rcv_d;
    logic [10:0]   exp_len, exp_len_d;
    logic [TW-1:0] tmo, tmo_d;
    logic [7:0]    cmd_d, char_d;
    logic          cmd_v_d, char_v_d, drop_d, timeout_d;
    logic [9:0]    char_idx_d;
`ifdef TERM_CURSOR_TRACK_EN
    logic [9:0]    cursor_d;
`endif

    req_t          req_code;
    logic          req_any, req_multi;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2:0]    fifo_rd;

    // Intake: one request per cycle, refresh > up > down > left > right.
    always_comb begin
        req_any  = 1'b1;
        req_code = REQ_UP;
        if (i_refresh)    req_code = REQ_REFRESH;
        else if (i_up)    req_code = REQ_UP;
        else if (i_down)  req_code = REQ_DOWN;
        else if (i_left)  req_code = REQ_LEFT;
        else if (i_right) req_code = REQ_RIGHT;
        else              req_any  = 1'b0;
    end

    assign req_multi = ($countones({i_refresh, i_up, i_down, i_left, i_right}) > 1);
    assign fifo_push = req_any && (!fifo_full || fifo_pop);
    assign drop_d    = req_multi || (req_any && fifo_full && !fifo_pop);
    assign o_busy    = (state != IDLE) || !fifo_empty;

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (req_code),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d    = state;
        hold_d     = hold_cnt;
        rcv_d      = rcv;
        exp_len_d  = exp_len;
        tmo_d      = tmo;
        cmd_d      = o_cmd;
        cmd_v_d    = o_cmd_v;
        char_d     = o_char;
        char_v_d   = 1'b0;
        char_idx_d = o_char_idx;
        timeout_d  = 1'b0;
        fifo_pop   = 1'b0;
`ifdef TERM_CURSOR_TRACK_EN
        cursor_d   = o_cursor_pos;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    cmd_d     = req_to_cmd(req_t'(fifo_rd));
                    cmd_v_d   = 1'b1;
                    exp_len_d = (req_t'(fifo_rd) == REQ_REFRESH) ? 11'(REFRESH_LEN) : 11'd1;
                    hold_d    = HW'(CMD_HOLD - 1);
                    state_d   = SEND;
`ifdef TERM_CURSOR_TRACK_EN
                    // 10-bit arithmetic gives the modulo-1024 wrap for free.
                    case (req_t'(fifo_rd))
                        REQ_UP:    cursor_d = o_cursor_pos - 10'(TERM_COLS);
                        REQ_DOWN:  cursor_d = o_cursor_pos + 10'(TERM_COLS);
                        REQ_LEFT:  cursor_d = o_cursor_pos - 10'd1;
                        REQ_RIGHT: cursor_d = o_cursor_pos + 10'd1;
                        default:   cursor_d = o_cursor_pos;
                    endcase
`endif
                end
            end
            SEND: begin
                if (hold_cnt == '0) begin
                    cmd_v_d = 1'b0;
                    rcv_d   = '0;
                    tmo_d   = '0;
                    state_d = WAIT;
                end else begin
                    hold_d = hold_cnt - HW'(1);
                end
            end
            WAIT: begin
                if (i_rsp_v) begin
                    char_d     = i_rsp;
                    char_v_d   = 1'b1;
                    char_idx_d = rcv[9:0];
                    rcv_d      = rcv + 11'd1;
                    tmo_d      = '0;
                    if (rcv + 11'd1 == exp_len) state_d = IDLE;
                end else if (tmo == TW'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            rcv          <= '0;
            exp_len      <= '0;
            tmo          <= '0;
            o_cmd        <= '0;
            o_cmd_v      <= 1'b0;
            o_char       <= '0;
            o_char_v     <= 1'b0;
            o_char_idx   <= '0;
            o_drop       <= 1'b0;
            o_timeout    <= 1'b0;
`ifdef TERM_CURSOR_TRACK_EN
            o_cursor_pos <= '0;
`endif
        end else begin
            state        <= state_d;
            hold_cnt     <= hold_d;
            rcv          <= rcv_d;
            exp_len      <= exp_len_d;
            tmo          <= tmo_d;
            o_cmd        <= cmd_d;
            o_cmd_v      <= cmd_v_d;
            o_char       <= char_d;
            o_char_v     <= char_v_d;
            o_char_idx   <= char_idx_d;
            o_drop       <= drop_d;
            o_timeout    <= timeout_d;
`ifdef TERM_CURSOR_TRACK_EN
            o_cursor_pos <= cursor_d;
`endif
        end
    end

endmodule
